// File: rtl/wb_pkg.sv
// wb_pkg: shared widths and the commit-entry type for the writeback commit unit
package wb_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_REGS = 32;
  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } entry_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: DEPTH-entry commit FIFO with same-edge push+pop
// Ports: clk, rst (async, active-high), push/din, pop/dout (head, combinational), full, empty.
module wb_fifo import wb_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  entry_t din,
  input  logic   pop,
  output entry_t dout,
  output logic   full,
  output logic   empty
);
  localparam int AW = $clog2(DEPTH);
  entry_t mem [DEPTH];
  logic [AW:0] wp, rp;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign dout = mem[rp[AW-1:0]];
  always_ff @(posedge clk)
    if (push) mem[wp[AW-1:0]] <= din;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + (AW+1)'(1);
      if (pop) rp <= rp + (AW+1)'(1);
    end
endmodule

// File: rtl/wb_commit_unit.sv
// wb_commit_unit: arbitrates ALU/load results into a commit FIFO, drains one per cycle to the register file, tracks pending writes
// Ports: clk, rst (async, active-high); a_*/b_* result handshakes; iss_valid/iss_rd issue marks;
// q1/q2 -> busy1/busy2 scoreboard queries; reg_write/rw/wd registered write port; err sticky protocol error.
// Macro WB_BYPASS_EN: an entry arriving while the FIFO is empty goes straight to the write port (latency 1).
module wb_commit_unit import wb_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_rd,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_rd,
  input  logic [DATA_W-1:0] b_data,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_rd,
  input  logic [ADDR_W-1:0] q1,
  input  logic [ADDR_W-1:0] q2,
  output logic              busy1,
  output logic              busy2,
  output logic              reg_write,
  output logic [ADDR_W-1:0] rw,
  output logic [DATA_W-1:0] wd,
  output logic              err
);
  entry_t in_e, head, wr_e;
  logic rr_b, gnt_a, gnt_b, xfer, bypass, pop, push, wr, full, empty;
  logic [NUM_REGS-1:0] sb, set_m, clr_m;
  assign gnt_b = b_valid && (rr_b || !a_valid);
  assign gnt_a = a_valid && !gnt_b;
  assign pop = !empty;
  // a full FIFO still pops this edge, so the slot frees in time for the push
  assign a_ready = !rst && gnt_a && (!full || pop);
  assign b_ready = !rst && gnt_b && (!full || pop);
  assign xfer = (a_valid && a_ready) || (b_valid && b_ready);
  assign in_e = gnt_b ? entry_t'{b_rd, b_data} : entry_t'{a_rd, a_data};
`ifdef WB_BYPASS_EN
  assign bypass = xfer && empty;
`else
  assign bypass = 1'b0;
`endif
  assign push = xfer && !bypass;
  assign wr = pop || bypass;
  assign wr_e = empty ? in_e : head;
  assign set_m = (iss_valid && iss_rd != '0) ? NUM_REGS'(1) << iss_rd : '0;
  assign clr_m = (wr && wr_e.rd != '0) ? NUM_REGS'(1) << wr_e.rd : '0;
  assign busy1 = q1 != '0 && sb[q1];
  assign busy2 = q2 != '0 && sb[q2];
  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (in_e),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rr_b <= 1'b1;
      sb <= '0;
      err <= 1'b0;
      reg_write <= 1'b0;
      rw <= '0;
      wd <= '0;
    end else begin
      if (xfer) rr_b <= gnt_a;
      sb <= (sb & ~clr_m) | set_m;
      err <= err || |(set_m & sb & ~clr_m) || |(clr_m & ~sb);
      reg_write <= |clr_m;
      if (|clr_m) begin
        rw <= wr_e.rd;
        wd <= wr_e.data;
      end
    end
endmodule
